vram_arbiter: RTL



---
 rtl/vram_pkg.sv | 19 +
 rtl/vram_arbiter_if.sv | 45 ++++
 rtl/vram_tag_pipe.sv | 24 ++
 rtl/vram_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared owner/tag types and default sizes for the VRAM arbiter
package vram_pkg;

  localparam int AW_DEF      = 18;
  localparam int DW_DEF      = 16;
  localparam int RD_LAT_DEF  = 2;
  localparam int VGA_MAX_DEF = 4;

  typedef enum logic {
    OWN_VGA = 1'b0,
    OWN_CPU = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - VGA/CPU requester and memory port bundle of the VRAM arbiter
interface vram_arbiter_if import vram_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr,
    output vga_gnt, vga_rvalid, vga_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output vga_req, vga_addr,
    input  vga_gnt, vga_rvalid, vga_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/vram_tag_pipe.sv
// rtl/vram_tag_pipe.sv - shift register carrying {valid, owner} for each issued access
module vram_tag_pipe import vram_pkg::*; #(
  parameter int DEPTH = RD_LAT_DEF + 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stages [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM sharing between VGA scan-out and CPU
// VGA has priority; a starve counter forces a CPU grant after VGA_MAX back-to-back VGA wins.
module vram_arbiter import vram_pkg::*; #(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int RD_LAT  = RD_LAT_DEF,
  parameter int VGA_MAX = VGA_MAX_DEF
) (
  input  logic           CLOCK,
  input  logic           rst,
  vram_arbiter_if.slave  bus
);

  localparam logic [3:0] VGA_MAX_C = 4'(VGA_MAX);

  logic          vga_gnt_c;
  logic          cpu_gnt_c;
  logic [3:0]    starve_cnt;

  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  logic          vga_rvalid_q;
  logic          cpu_rvalid_q;
  logic [DW-1:0] vga_rdata_q;
  logic [DW-1:0] cpu_rdata_q;

  tag_t          tag_in;
  tag_t          tag_out;

  // Grants are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    vga_gnt_c = 1'b0;
    cpu_gnt_c = 1'b0;
    if (!rst) begin
      if (bus.vga_req && bus.cpu_req) begin
        if (starve_cnt == VGA_MAX_C) cpu_gnt_c = 1'b1;
        else                         vga_gnt_c = 1'b1;
      end else begin
        vga_gnt_c = bus.vga_req;
        cpu_gnt_c = bus.cpu_req;
      end
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (cpu_gnt_c || !bus.cpu_req) begin
      starve_cnt <= 4'd0;
    end else if (vga_gnt_c && starve_cnt != VGA_MAX_C) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= vga_gnt_c | cpu_gnt_c;
      mem_we_q <= cpu_gnt_c & bus.cpu_we;
      if (cpu_gnt_c)      mem_addr_q <= bus.cpu_addr;
      else if (vga_gnt_c) mem_addr_q <= bus.vga_addr;
      if (cpu_gnt_c && bus.cpu_we) mem_wdata_q <= bus.cpu_wdata;
    end
  end

  // Writes enter the pipe as bubbles so they never produce an rvalid.
  assign tag_in.valid = vga_gnt_c | (cpu_gnt_c & ~bus.cpu_we);
  assign tag_in.owner = cpu_gnt_c ? OWN_CPU : OWN_VGA;

  vram_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_tag_pipe (
    .clk     (CLOCK),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      vga_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vga_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      vga_rvalid_q <= tag_out.valid && (tag_out.owner == OWN_VGA);
      cpu_rvalid_q <= tag_out.valid && (tag_out.owner == OWN_CPU);
      if (tag_out.valid && tag_out.owner == OWN_VGA) vga_rdata_q <= bus.mem_rdata;
      if (tag_out.valid && tag_out.owner == OWN_CPU) cpu_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.vga_gnt    = vga_gnt_c;
  assign bus.cpu_gnt    = cpu_gnt_c;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.vga_rvalid = vga_rvalid_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.vga_rdata  = vga_rdata_q;
  assign bus.cpu_rdata  = cpu_rdata_q;

endmodule
